// File: rtl/stream_demux1x2_pkg.sv
// Shared constants for the 1:2 stream demultiplexer: lane indices and the
// HEAD/BODY packet-tracking state encoding.
package stream_demux1x2_pkg;

    // Lane index values, as carried on in_sel and held in locked_sel
    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // HEAD: next accepted beat starts a packet; BODY: inside a multi-beat packet
    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO skid stage carrying data+last. in_ready comes straight from
// a flop, so nothing downstream of out_ready reaches in_ready combinationally.
//
// Handshake: a beat moves on a port exactly when valid && ready at a rising
// edge; valid never depends on ready on the same port.
module stream_skid2
    import stream_demux1x2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    // Entry 0 is always the oldest beat; entry 1 only holds data at occupancy 2
    logic [WIDTH:0] r_ent0;
    logic [WIDTH:0] r_ent1;
    logic [1:0]     r_count;
    logic           r_not_full;

    logic           w_push;
    logic           w_pop;
    logic [1:0]     w_count_nxt;
    logic [WIDTH:0] w_in_ent;

    assign w_in_ent  = {in_last, in_data};
    assign w_push    = in_valid && r_not_full;
    assign w_pop     = (r_count != 2'd0) && out_ready;

    assign in_ready  = r_not_full;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_ent0[WIDTH-1:0];
    assign out_last  = r_ent0[WIDTH];

    // Next occupancy: push and pop together leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Storage shift/fill and the registered not-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0     <= '0;
            r_ent1     <= '0;
            r_count    <= 2'd0;
            r_not_full <= 1'b1;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= w_in_ent;
                    else                 r_ent1 <= w_in_ent;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= w_in_ent;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_in_ent;
                    end
                end
                default: ;
            endcase
            r_count    <= w_count_nxt;
            r_not_full <= (w_count_nxt <= 2'd1);
        end
    end

endmodule

// File: rtl/stream_demux1x2.sv
// Packet-granular 1:2 valid/ready demultiplexer. The lane is chosen from
// in_sel on the head beat and held until the last beat is accepted. Each
// lane has its own 2-entry skid stage; a full selected lane stalls the input
// even when the other lane is idle (head-of-line blocking is intended).
//
// Handshake: a beat transfers on any port when valid && ready at a rising
// edge; in_ready is a function of registered lane fullness and the route only.
module stream_demux1x2
    import stream_demux1x2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_locked_sel;

    logic   w_route;
    logic   w_accept;
    logic   w_push0;
    logic   w_push1;
    logic   w_s0_not_full;
    logic   w_s1_not_full;

    // State register and the lane locked for the rest of a multi-beat packet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HEAD;
            r_locked_sel <= LANE0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && (r_state == HEAD) && !in_last) begin
                r_locked_sel <= in_sel;
            end
        end
    end

    // Next state: a non-last head opens a packet, a last beat in BODY closes it
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                HEAD:    if (!in_last) w_state_nxt = BODY;
                BODY:    if (in_last)  w_state_nxt = HEAD;
                default: w_state_nxt = HEAD;
            endcase
        end
    end

    // Outputs: route mux, in_ready from the selected lane, per-lane push
    always_comb begin
        w_route  = (r_state == HEAD) ? in_sel : r_locked_sel;
        in_ready = !rst && ((w_route == LANE1) ? w_s1_not_full : w_s0_not_full);
        w_accept = in_valid && in_ready;
        w_push0  = w_accept && (w_route == LANE0);
        w_push1  = w_accept && (w_route == LANE1);
    end

    stream_skid2 #(.WIDTH(WIDTH)) u_skid0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_push0),
        .in_ready  (w_s0_not_full),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out0_valid),
        .out_ready (out0_ready),
        .out_data  (out0_data),
        .out_last  (out0_last)
    );

    stream_skid2 #(.WIDTH(WIDTH)) u_skid1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_push1),
        .in_ready  (w_s1_not_full),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .out_data  (out1_data),
        .out_last  (out1_last)
    );

endmodule

// File: tb/tb_stream_demux1x2.sv
// Directed bench for stream_demux1x2: the driver pushes the hand-chosen
// destination lane of every accepted beat into a per-lane expected queue; a
// monitor pops and compares whenever a lane hands a beat to its consumer.
module tb_stream_demux1x2;
    import stream_demux1x2_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_last;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out1_data;
    logic         out1_last;
    logic         out1_valid;
    logic         out1_ready;

    // Expected beats per lane, packed as {last, data}
    logic [W:0] exp0_q[$];
    logic [W:0] exp1_q[$];

    int total;
    int bad;
    int n_pop0;
    int n_pop1;

    stream_demux1x2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one beat, wait for acceptance, record the expected lane.
    // exp_lane 2 means the beat is expected to be discarded by a reset.
    task automatic send_beat(input logic [W-1:0] d, input logic sel, input logic last,
                             input int exp_lane, output int stalls);
        int  waited;
        logic acc;
        stalls   = 0;
        waited   = 0;
        acc      = 1'b0;
        in_data  = d;
        in_sel   = sel;
        in_last  = last;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
            end else begin
                stalls++;
                waited++;
                if (waited > 50) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: beat %0h not accepted, in_ready=%0b", d, in_ready);
                    break;
                end
            end
        end
        if (acc) begin
            if (exp_lane == 0) exp0_q.push_back({last, d});
            else if (exp_lane == 1) exp1_q.push_back({last, d});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (out0_valid && out0_ready) begin
                n_pop0++;
                total++;
                if (exp0_q.size() == 0) begin
                    bad++;
                    $display("FAIL lane0_unexpected: got %0b/%0h, expected no beat", out0_last, out0_data);
                end else begin
                    logic [W:0] e;
                    e = exp0_q.pop_front();
                    if ({out0_last, out0_data} !== e) begin
                        bad++;
                        $display("FAIL lane0_beat: got %0b/%0h, expected %0b/%0h",
                                 out0_last, out0_data, e[W], e[W-1:0]);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                n_pop1++;
                total++;
                if (exp1_q.size() == 0) begin
                    bad++;
                    $display("FAIL lane1_unexpected: got %0b/%0h, expected no beat", out1_last, out1_data);
                end else begin
                    logic [W:0] e;
                    e = exp1_q.pop_front();
                    if ({out1_last, out1_data} !== e) begin
                        bad++;
                        $display("FAIL lane1_beat: got %0b/%0h, expected %0b/%0h",
                                 out1_last, out1_data, e[W], e[W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int st;
        int st_sum;
        int pops_before;

        total      = 0;
        bad        = 0;
        n_pop0     = 0;
        n_pop1     = 0;
        rst        = 1'b1;
        in_data    = '0;
        in_last    = 1'b0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   in_ready,   0);
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data",  {out0_last, out0_data}, 0);
        check("rst_out1_data",  {out1_last, out1_data}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Reset mid-packet: two BODY-opening beats to lane 1, then reset
        send_beat(8'hB0, 1'b1, 1'b0, 2, st);
        send_beat(8'hB1, 1'b1, 1'b0, 2, st);
        check("midpkt_state_body", dut.r_state, BODY);
        rst = 1'b1;
        @(negedge clk);
        check("midpkt_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        check("midpkt_out1_valid", out1_valid, 0);
        check("midpkt_state_head", dut.r_state, HEAD);
        @(posedge clk);
        #1;
        send_beat(8'h5A, 1'b0, 1'b1, 0, st);
        check("midpkt_5a_visible", {out0_valid, out0_last, out0_data}, {2'b11, 8'h5A});
        idle(3);

        // Single-beat routing, back-to-back
        send_beat(8'h11, 1'b0, 1'b1, 0, st);
        st_sum = st;
        check("single_11_latency", {out0_valid, out0_data}, {1'b1, 8'h11});
        send_beat(8'h22, 1'b1, 1'b1, 1, st);
        st_sum += st;
        check("single_22_latency", {out1_valid, out1_data}, {1'b1, 8'h22});
        send_beat(8'h33, 1'b0, 1'b1, 0, st);
        st_sum += st;
        check("single_33_latency", {out0_valid, out0_data}, {1'b1, 8'h33});
        check("single_no_stall", st_sum, 0);
        idle(3);

        // Packet lock: in_sel toggled after the head must be ignored
        pops_before = n_pop0;
        send_beat(8'hA0, 1'b1, 1'b0, 1, st);
        check("lock_state_body", dut.r_state, BODY);
        send_beat(8'hA1, 1'b0, 1'b0, 1, st);
        send_beat(8'hA2, 1'b0, 1'b0, 1, st);
        send_beat(8'hA3, 1'b0, 1'b1, 1, st);
        check("lock_state_head", dut.r_state, HEAD);
        idle(4);
        check("lock_out0_idle", n_pop0 - pops_before, 0);

        // Backpressure and skid on lane 0
        out0_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_beat(8'hC0 + 8'(i), 1'b0, 1'b1, 0, st);
                end
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_full_in_ready", in_ready, 0);
                check("bp_full_count", 32'(dut.u_skid0.r_count), 2);
                check("bp_oldest", out0_data, 8'hC0);
                @(posedge clk);
                #1;
                out0_ready = 1'b1;
                @(negedge clk);
                check("bp_before_pop_in_ready", in_ready, 0);
                @(negedge clk);
                check("bp_after_pop_in_ready", in_ready, 1);
            end
        join
        idle(4);

        // Head-of-line blocking: full lane 0 stalls a lane-1 beat behind it
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        send_beat(8'hD0, 1'b0, 1'b1, 0, st);
        send_beat(8'hD1, 1'b0, 1'b1, 0, st);
        fork
            begin
                send_beat(8'hD2, 1'b0, 1'b1, 0, st);
                send_beat(8'hE0, 1'b1, 1'b1, 1, st);
                check("hol_e0_no_stall", st, 0);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("hol_in_ready", in_ready, 0);
                    check("hol_out1_idle", out1_valid, 0);
                end
                @(posedge clk);
                #1;
                out0_ready = 1'b1;
            end
        join
        idle(4);

        // Simultaneous push/pop on lane 1 at occupancy 1
        out1_ready = 1'b0;
        send_beat(8'hF0, 1'b1, 1'b1, 1, st);
        out1_ready = 1'b1;
        pops_before = n_pop1;
        st_sum = 0;
        for (int i = 1; i <= 8; i++) begin
            send_beat(8'hF0 + 8'(i), 1'b1, 1'b1, 1, st);
            st_sum += st;
            check("pp_count", 32'(dut.u_skid1.r_count), 1);
        end
        check("pp_no_stall", st_sum, 0);
        check("pp_rate", n_pop1 - pops_before, 8);
        idle(6);

        // Everything expected has drained
        check("end_q0_empty", exp0_q.size(), 0);
        check("end_q1_empty", exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
